// File: rtl/gf_mul_pipe.sv
// gf_mul_pipe: GF(2^8) multiplier (poly 0x11D, alpha=0x02) via log/antilog lookups, three register stages.
// Latency 3 cycles, 1/cycle; full valid/ready backpressure, stall ripples back combinationally, bubbles collapse.
// Define GF_MUL_DIV_EN to add in_op (1 = a/b) and out_err (divide by zero).

module gf_log (
  input  logic [7:0] val_i,
  output logic [7:0] log_o
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] log_of(input logic [7:0] v);
    logic [7:0] p;
    logic [7:0] k_found;
    p = 8'h01;
    k_found = 8'h00;
    for (int k = 0; k < 255; k++) begin
      if (p == v) k_found = k[7:0];
      p = xtime(p);
    end
    return k_found;
  endfunction

  logic [7:0] rom [256];

  // log(0) does not exist; the consumer masks it with its zero flag
  assign rom[0] = 8'h00;
  for (genvar v = 1; v < 256; v++) begin : g_rom
    localparam logic [7:0] K = log_of(8'(v));
    assign rom[v] = K;
  end

  assign log_o = rom[val_i];
endmodule

module gf_mul_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_p,
  output logic [TAG_W-1:0] out_tag
`ifdef GF_MUL_DIV_EN
  ,
  input  logic             in_op,
  output logic             out_err
`endif
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] pow_of(input logic [7:0] k);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      if (i < int'(k)) p = xtime(p);
    end
    return p;
  endfunction

  logic [7:0] antilog [256];
  for (genvar k = 0; k < 256; k++) begin : g_antilog
    localparam logic [7:0] P = pow_of(8'(k));
    assign antilog[k] = P;
  end

  logic             v1_q, v2_q, v3_q;
  logic             v1_d, v2_d, v3_d;
  logic             ld1, ld2, ld3;
  logic [7:0]       a1_q, b1_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic             z1_q, z2_q;
  logic [7:0]       e2_q, e2_d;
  logic [7:0]       p3_q, p3_d;
  logic [7:0]       log_a, log_b;
  logic [8:0]       sum;
`ifdef GF_MUL_DIV_EN
  logic             op1_q, err1_q, err2_q, err3_q;
  logic [8:0]       diff;
`endif

  gf_log u_log_a (.val_i(a1_q), .log_o(log_a));
  gf_log u_log_b (.val_i(b1_q), .log_o(log_b));

  always_comb begin
    ld3  = !v3_q || out_ready;
    ld2  = !v2_q || ld3;
    ld1  = !v1_q || ld2;
    v1_d = ld1 ? in_valid : v1_q;
    v2_d = ld2 ? v1_q : v2_q;
    v3_d = ld3 ? v2_q : v3_q;
    sum  = {1'b0, log_a} + {1'b0, log_b};
    // sum is 255..508 when wrapping: subtracting 255 equals adding 1 mod 256
    e2_d = (sum >= 9'd255) ? (sum[7:0] + 8'd1) : sum[7:0];
`ifdef GF_MUL_DIV_EN
    diff = {1'b0, log_a} - {1'b0, log_b};
    if (op1_q) e2_d = diff[8] ? (diff[7:0] + 8'd255) : diff[7:0];
`endif
    p3_d = z2_q ? 8'h00 : antilog[e2_q];
  end

  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign out_p     = p3_q;
  assign out_tag   = tag3_q;
`ifdef GF_MUL_DIV_EN
  assign out_err   = err3_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p3_q   <= 8'h00;
      tag3_q <= '0;
`ifdef GF_MUL_DIV_EN
      err3_q <= 1'b0;
`endif
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (ld3 && v2_q) begin
        p3_q   <= p3_d;
        tag3_q <= tag2_q;
`ifdef GF_MUL_DIV_EN
        err3_q <= err2_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      a1_q   <= in_a;
      b1_q   <= in_b;
      tag1_q <= in_tag;
      z1_q   <= (in_a == 8'h00) || (in_b == 8'h00);
`ifdef GF_MUL_DIV_EN
      op1_q  <= in_op;
      err1_q <= in_op && (in_b == 8'h00);
`endif
    end
    if (ld2 && v1_q) begin
      e2_q   <= e2_d;
      z2_q   <= z1_q;
      tag2_q <= tag1_q;
`ifdef GF_MUL_DIV_EN
      err2_q <= err1_q;
`endif
    end
  end
endmodule

// File: tb/tb_gf_mul_pipe.sv
// Bench for gf_mul_pipe: directed vector table, stall/reset sequences, exhaustive multiply
// sweep and random valid/ready traffic checked against a shift-and-add GF(2^8) model.
module tb_gf_mul_pipe;
  localparam int TAG_W = 4;

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic             op;
    logic [TAG_W-1:0] tag;
    logic [7:0]       p;
    logic             err;
  } vec_t;

  typedef struct {
    logic [7:0]       p;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [7:0]       in_a, in_b, out_p;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef GF_MUL_DIV_EN
  logic             in_op, out_err;
`endif

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  bit         sb_en = 1'b0;
  bit         last_xfer = 1'b0;
  bit         hold_pend = 1'b0;
  logic [7:0] hold_p;
  logic [TAG_W-1:0] hold_tag;

  always #5 clk = ~clk;

  gf_mul_pipe #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_tag  (out_tag)
`ifdef GF_MUL_DIV_EN
    ,
    .in_op    (in_op),
    .out_err  (out_err)
`endif
  );

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q;
    q = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (ref_mul(8'(i), b) == a) q = 8'(i);
    end
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Runs at the falling edge: predicts the transfers of the coming rising edge.
  task automatic monitor();
    exp_t e;
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
      last_xfer = 1'b0;
      return;
    end
    if (hold_pend) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_p", 32'(out_p), 32'(hold_p));
      check("hold_tag", 32'(out_tag), 32'(hold_tag));
    end
    hold_pend = out_valid && !out_ready;
    hold_p    = out_p;
    hold_tag  = out_tag;
    last_xfer = in_valid && in_ready;
    if (sb_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra actual=%0h required=no_output", out_p);
        end else begin
          e = exp_q.pop_front();
          check("sb_p", 32'(out_p), 32'(e.p));
          check("sb_tag", 32'(out_tag), 32'(e.tag));
`ifdef GF_MUL_DIV_EN
          check("sb_err", 32'(out_err), 32'(e.err));
`endif
        end
      end
      if (last_xfer) begin
        e.tag = in_tag;
        e.p   = ref_mul(in_a, in_b);
        e.err = 1'b0;
`ifdef GF_MUL_DIV_EN
        if (in_op) begin
          e.err = (in_b == 8'h00);
          e.p   = (in_b == 8'h00) ? 8'h00 : ref_div(in_a, in_b);
        end
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic op,
                      input logic [TAG_W-1:0] tag);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
`ifdef GF_MUL_DIV_EN
    in_op    = op;
`else
    if (op) in_tag = tag;
`endif
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_xfer && n < 100);
    if (!last_xfer) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    int   acc;
    int   n;
    bit   seen;

    vecs.push_back('{8'h02, 8'h80, 1'b0, 4'h1, 8'h1D, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 4'h2, 8'h13, 1'b0});
    vecs.push_back('{8'h03, 8'h03, 1'b0, 4'h3, 8'h05, 1'b0});
    vecs.push_back('{8'h01, 8'h5A, 1'b0, 4'h4, 8'h5A, 1'b0});
    vecs.push_back('{8'h00, 8'h37, 1'b0, 4'h5, 8'h00, 1'b0});
    vecs.push_back('{8'h8E, 8'h02, 1'b0, 4'h6, 8'h01, 1'b0});
    vecs.push_back('{8'h8E, 8'h8E, 1'b0, 4'h7, 8'h47, 1'b0});
    vecs.push_back('{8'hFF, 8'h00, 1'b0, 4'h8, 8'h00, 1'b0});
    vecs.push_back('{8'h01, 8'h01, 1'b0, 4'h9, 8'h01, 1'b0});
`ifdef GF_MUL_DIV_EN
    vecs.push_back('{8'h1D, 8'h80, 1'b1, 4'hA, 8'h02, 1'b0});
    vecs.push_back('{8'h37, 8'h00, 1'b1, 4'hB, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h05, 1'b1, 4'hC, 8'h00, 1'b0});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 4'hD, 8'h8E, 1'b0});
    in_op = 1'b0;
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef GF_MUL_DIV_EN
    check("rst_out_err", 32'(out_err), 32'd0);
`endif
    rst       = 1'b0;
    out_ready = 1'b1;

    // Directed table: back-to-back, one result per cycle exactly 3 cycles after acceptance
    for (int c = 0; c < vecs.size() + 3; c++) begin
      if (c >= 3) begin
        check("vec_valid", 32'(out_valid), 32'd1);
        check("vec_p", 32'(out_p), 32'(vecs[c-3].p));
        check("vec_tag", 32'(out_tag), 32'(vecs[c-3].tag));
`ifdef GF_MUL_DIV_EN
        check("vec_err", 32'(out_err), 32'(vecs[c-3].err));
`endif
      end else begin
        check("vec_latency", 32'(out_valid), 32'd0);
      end
      if (c < vecs.size()) begin
        in_valid = 1'b1;
        in_a     = vecs[c].a;
        in_b     = vecs[c].b;
        in_tag   = vecs[c].tag;
`ifdef GF_MUL_DIV_EN
        in_op    = vecs[c].op;
`endif
      end else begin
        in_valid = 1'b0;
      end
      check("vec_in_ready", 32'(in_ready), 32'd1);
      tick();
    end

    // Backpressure: three stages fill, then in_ready drops and outputs hold
    sb_en     = 1'b1;
    out_ready = 1'b0;
    acc       = 0;
    in_valid  = 1'b1;
    in_a      = 8'h53;
    in_b      = 8'h11;
    in_tag    = 4'h1;
`ifdef GF_MUL_DIV_EN
    in_op     = 1'b0;
`endif
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_xfer) begin
        acc++;
        in_a   = in_a + 8'h01;
        in_tag = in_tag + 4'h1;
      end
    end
    check("bp_accepted", 32'(acc), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_xfer && n < 20);
    check("bp_release_accept", 32'(last_xfer), 32'd1);
    drain();

    // Asynchronous reset with three results in flight
    out_ready = 1'b0;
    send(8'h02, 8'h02, 1'b0, 4'hA);
    send(8'h04, 8'h04, 1'b0, 4'hB);
    send(8'h08, 8'h08, 1'b0, 4'hC);
    in_valid = 1'b0;
    check("rif_full", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rif_out_valid", 32'(out_valid), 32'd0);
    check("rif_in_ready", 32'(in_ready), 32'd1);
    check("rif_out_p", 32'(out_p), 32'd0);
    check("rif_out_tag", 32'(out_tag), 32'd0);
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rif_stale", 32'(seen), 32'd0);

    // Every nonzero operand pair: wrap at sums 254, 255 and 508
    for (int a = 1; a < 256; a++) begin
      for (int b = 1; b < 256; b++) begin
        send(8'(a), 8'(b), 1'b0, TAG_W'(a ^ b));
      end
    end
    drain();

    // Random traffic, random stalls, frequent zero operands
    in_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || last_xfer) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        in_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        in_tag   = TAG_W'($urandom);
`ifdef GF_MUL_DIV_EN
        in_op    = 1'($urandom);
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
